// File: rtl/k_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// k_fetch_sequencer
//
// Streams K_LENGTH 32-bit round constants out of a synchronous-read constant
// SRAM and hands them, one indexed word at a time, to the k-vector builder.
//
// Optional build macro:
//   K_FETCH_PIPELINE_EN  - defined:   a read strobe every cycle, captures overlap
//                                     issues, one word per cycle after a 2-cycle fill
//                          undefined: ISSUE and CAPTURE alternate, one word
//                                     every 2 cycles
//
// Ports:
//   clock                  in   single clock, rising-edge
//   reset_n                in   asynchronous active-low reset
//   start                  in   one-cycle pass request (ignored while busy)
//   clear                  in   synchronous abort to IDLE, overrides start
//   k_sram_read_en         out  SRAM read strobe
//   k_sram_address         out  SRAM word address
//   k_sram_data            in   SRAM read data, valid the cycle after the strobe
//   k_address              out  index of the word on k_data
//   k_data                 out  registered constant word
//   k_valid                out  k_address/k_data are new this cycle
//   address_read_complete  out  all K_LENGTH words delivered, held until start/clear
//   busy                   out  high in every state except IDLE and DONE
//   o_dbg_state            out  current FSM state encoding
//
// Handshake: there is no back-pressure. A strobe on k_sram_read_en is answered
// by the SRAM on the following cycle, and every answered strobe produces
// exactly one single-cycle k_valid pulse one cycle after that.
// ---------------------------------------------------------------------------
module k_fetch_sequencer #(
    parameter int K_LENGTH = 64
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        clear,
    output logic                        k_sram_read_en,
    output logic [$clog2(K_LENGTH)-1:0] k_sram_address,
    input  logic [31:0]                 k_sram_data,
    output logic [$clog2(K_LENGTH)-1:0] k_address,
    output logic [31:0]                 k_data,
    output logic                        k_valid,
    output logic                        address_read_complete,
    output logic                        busy,
    output logic [2:0]                  o_dbg_state
);

    localparam int AW = $clog2(K_LENGTH);
    // One extra counter bit so that a counter can reach K_LENGTH without wrapping.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_ADDR = CW'(K_LENGTH - 1);
    localparam logic [CW-1:0] K_COUNT   = CW'(K_LENGTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_rd_cnt;
    logic [CW-1:0]   r_cap_cnt;
    logic            r_inflight;     // a strobe was issued last cycle
    logic            r_k_valid;
    logic [AW-1:0]   r_k_address;
    logic [31:0]     r_k_data;
    logic            w_strobe;
    logic            w_begin_pass;
    logic            w_last_valid;

    // The final word is on the outputs once the capture counter has reached K_LENGTH.
    assign w_last_valid = r_k_valid && (r_cap_cnt == K_COUNT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_strobe     = 1'b0;
        w_begin_pass = 1'b0;
        if (clear) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_next_state = S_ISSUE;
                        w_begin_pass = 1'b1;
                    end
                end
                S_ISSUE: begin
                    w_strobe = 1'b1;
                    if (r_rd_cnt == LAST_ADDR) begin
                        w_next_state = S_DRAIN;
                    end else begin
`ifdef K_FETCH_PIPELINE_EN
                        w_next_state = S_ISSUE;
`else
                        w_next_state = S_CAPTURE;
`endif
                    end
                end
                S_CAPTURE: w_next_state = S_ISSUE;
                S_DRAIN: begin
                    if (w_last_valid) begin
                        w_next_state = S_DONE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_cnt    <= '0;
            r_cap_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_k_valid   <= 1'b0;
            r_k_address <= '0;
            r_k_data    <= '0;
        end else if (clear) begin
            // Abort drops any word still in flight; k_address/k_data keep their value.
            r_rd_cnt   <= '0;
            r_cap_cnt  <= '0;
            r_inflight <= 1'b0;
            r_k_valid  <= 1'b0;
        end else begin
            r_inflight <= w_strobe;
            r_k_valid  <= r_inflight;
            if (w_begin_pass) begin
                r_rd_cnt  <= '0;
                r_cap_cnt <= '0;
            end else begin
                if (w_strobe) begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
                if (r_inflight) begin
                    r_cap_cnt <= r_cap_cnt + 1'b1;
                end
            end
            // SRAM data is valid in the cycle after the strobe; register it then.
            if (r_inflight) begin
                r_k_data    <= k_sram_data;
                r_k_address <= r_cap_cnt[AW-1:0];
            end
        end
    end

    assign k_sram_read_en        = w_strobe;
    assign k_sram_address        = w_strobe ? r_rd_cnt[AW-1:0] : '0;
    assign k_address             = r_k_address;
    assign k_data                = r_k_data;
    assign k_valid               = r_k_valid;
    assign address_read_complete = (r_state == S_DONE);
    assign busy                  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_k_fetch_sequencer.sv
module tb_k_fetch_sequencer;

  localparam int K = 64;
  localparam int AW = $clog2(K);
  localparam int W = AW + 32;
`ifdef K_FETCH_PIPELINE_EN
  localparam int EXP_CYC = K + 2;
`else
  localparam int EXP_CYC = 2 * K + 1;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic start, clear;
  logic k_sram_read_en;
  logic [AW-1:0] k_sram_address;
  logic [31:0] k_sram_data;
  logic [AW-1:0] k_address;
  logic [31:0] k_data;
  logic k_valid, address_read_complete, busy;
  logic [2:0] dbg_state;

  k_fetch_sequencer #(.K_LENGTH(K)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .clear(clear),
    .k_sram_read_en(k_sram_read_en),
    .k_sram_address(k_sram_address),
    .k_sram_data(k_sram_data),
    .k_address(k_address),
    .k_data(k_data),
    .k_valid(k_valid),
    .address_read_complete(address_read_complete),
    .busy(busy),
    .o_dbg_state(dbg_state)
  );

  // ---------------- SRAM model: SHA-256 K table, 1-cycle read ----------------
  logic [31:0] ktab [0:K-1] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  always @(posedge clock) begin
    if (k_sram_read_en) k_sram_data <= ktab[k_sram_address];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int exp_rd;           // next SRAM address the pass should strobe
  bit pass_active;      // strobes are legal only inside an accepted pass
  bit last_seen;        // previous cycle carried the final word
  logic [AW-1:0] last_addr;
  logic [31:0] last_data;

  task automatic flush_model(input bit zero_outputs);
    exp_q.delete();
    exp_rd = 0;
    pass_active = 0;
    last_seen = 0;
    if (zero_outputs) begin
      last_addr = '0;
      last_data = '0;
    end
  endtask

  task automatic load_pass();
    exp_q.delete();
    for (int i = 0; i < K; i++) exp_q.push_back({AW'(i), ktab[i]});
    exp_rd = 0;
    pass_active = 1;
    last_seen = 0;
  endtask

  // Monitor samples on the falling edge, half a cycle away from the active edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (k_sram_read_en) begin
        if (pass_active && exp_rd < K) begin
          check_eq("sram_address", k_sram_address, exp_rd);
          exp_rd++;
        end else begin
          check_eq("strobe_unexpected", k_sram_read_en, 0);
        end
      end
      if (last_seen) begin
        check_eq("complete_after_last", address_read_complete, 1);
        last_seen = 0;
      end
      if (k_valid) begin
        check_eq("complete_low_while_valid", address_read_complete, 0);
        if (exp_q.size() == 0) begin
          check_eq("k_valid_unexpected", k_valid, 0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check_eq("k_address", k_address, e[W-1:32]);
          check_eq("k_data", k_data, e[31:0]);
          last_addr = e[W-1:32];
          last_data = e[31:0];
          if (int'(e[W-1:32]) == K - 1) last_seen = 1;
        end
      end else begin
        check_eq("k_address_hold", k_address, last_addr);
        check_eq("k_data_hold", k_data, last_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_all_zero(input string tag);
    check_eq({tag, "_read_en"}, k_sram_read_en, 0);
    check_eq({tag, "_sram_addr"}, k_sram_address, 0);
    check_eq({tag, "_k_address"}, k_address, 0);
    check_eq({tag, "_k_data"}, k_data, 0);
    check_eq({tag, "_k_valid"}, k_valid, 0);
    check_eq({tag, "_complete"}, address_read_complete, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // action: 0 plain pass, 1 start pulses at hit, 2 clear at hit, 3 reset at hit
  task automatic run_pass(input int hit_idx, input int action);
    int cyc;
    int spam;
    bit stop;
    bit hit;
    load_pass();
    @(posedge clock); #1 start = 1;
    @(posedge clock); #1 start = 0;
    check_eq("busy_after_start", busy, 1);
    check_eq("complete_cleared_on_start", address_read_complete, 0);
    cyc = 0;
    spam = 0;
    stop = 0;
    while (!address_read_complete && cyc < 1000 && !stop) begin
      hit = k_valid && (int'(k_address) == hit_idx);
      if (action == 1 && hit) spam = $urandom_range(1, 5);
      start = (spam > 0);
      if (spam > 0) spam--;
      if (action == 2 && hit) begin
        clear = 1;
        start = 1;
        @(posedge clock); #1;
        clear = 0;
        start = 0;
        check_eq("clear_read_en", k_sram_read_en, 0);
        check_eq("clear_k_valid", k_valid, 0);
        check_eq("clear_busy", busy, 0);
        check_eq("clear_complete", address_read_complete, 0);
        flush_model(0);
        stop = 1;
      end else if (action == 3 && hit) begin
        #2 reset_n = 0;
        #1 check_all_zero("async_reset");
        flush_model(1);
        @(posedge clock); #1 reset_n = 1;
        stop = 1;
      end
      if (!stop) begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    start = 0;
    if (action <= 1) begin
      check_eq("pass_cycles", cyc, EXP_CYC);
      check_eq("busy_at_done", busy, 0);
      check_eq("scoreboard_empty", exp_q.size(), 0);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 0;
    start = 0;
    clear = 0;
    flush_model(1);
    idle_cycles(3);
    check_all_zero("reset");
    reset_n = 1;
    idle_cycles(2);

    // Full pass, then complete must hold through idle cycles.
    run_pass(-1, 0);
    idle_cycles(10);
    check_eq("complete_holds", address_read_complete, 1);
    check_eq("busy_idle_done", busy, 0);

    // Start pulses mid-pass are ignored (fixed point and random point).
    run_pass(20, 1);
    idle_cycles($urandom_range(1, 6));
    run_pass($urandom_range(1, K - 2), 1);

    // Clear at capture 30, quiet period, then a clean restart.
    idle_cycles($urandom_range(1, 6));
    run_pass(30, 2);
    idle_cycles(5);
    check_eq("idle_after_clear_busy", busy, 0);
    run_pass(-1, 0);

    // Reset at capture 15, then a clean pass.
    idle_cycles($urandom_range(1, 6));
    run_pass(15, 3);
    idle_cycles(2);
    check_all_zero("after_reset_release");
    run_pass(-1, 0);
    idle_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/k_fetch_sequencer.md
K_FETCH_SEQUENCER -- requirements
Module: k_fetch_sequencer

Interface
REQ-001 SHALL provide parameter K_LENGTH, default 64: number of 32-bit round constants fetched per pass.
REQ-002 SHALL provide port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL provide port start, input, 1: one-cycle request to begin a fetch pass.
REQ-005 SHALL provide port clear, input, 1: synchronous abort that returns the block to IDLE.
REQ-006 SHALL provide port k_sram_read_en, output, 1: read strobe to the constant SRAM.
REQ-007 SHALL provide port k_sram_address, output, $clog2(K_LENGTH): SRAM word address.
REQ-008 SHALL provide port k_sram_data, input, 32: SRAM read data, valid the cycle after the strobe.
REQ-009 SHALL provide port k_address, output, $clog2(K_LENGTH): index of the word on k_data, to the k-vector builder.
REQ-010 SHALL provide port k_data, output, 32: registered constant word.
REQ-011 SHALL provide port k_valid, output, 1: k_address/k_data are new this cycle.
REQ-012 SHALL provide port address_read_complete, output, 1: all K_LENGTH words delivered.
REQ-013 SHALL provide port busy, output, 1: high in every state except IDLE and DONE.

Function
REQ-014 SHALL implement the states IDLE, ISSUE, CAPTURE, DRAIN and DONE.
REQ-015 IDLE SHALL move to ISSUE on start=1, with read counter and capture counter at 0.
REQ-016 ISSUE SHALL drive k_sram_read_en=1 with k_sram_address=read counter, then increment the read counter.
REQ-017 k_sram_data SHALL be registered into k_data, with k_address=capture counter, on the edge ending the cycle after the strobe, so k_valid is high exactly one cycle, two cycles after the strobe cycle.
REQ-018 Without pipelining, ISSUE and CAPTURE SHALL alternate, giving one word every 2 cycles.
REQ-019 After the strobe for address K_LENGTH-1, the block SHALL enter DRAIN until the last word is captured, then enter DONE.
REQ-020 address_read_complete SHALL rise the cycle after the final k_valid and SHALL hold until start or clear.
REQ-021 k_address and k_data SHALL hold their last values while k_valid=0.
REQ-022 DONE SHALL move to ISSUE on start, starting a new pass from address 0 and deasserting address_read_complete in that cycle.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 clear SHALL override start in every state and SHALL move the block to IDLE at the next edge: strobe deasserted, counters zeroed, k_valid=0, address_read_complete=0.
REQ-025 k_sram_read_en SHALL never be asserted for an address of K_LENGTH or above; counters SHALL NOT wrap within a pass.

Reset
REQ-026 While reset_n=0, the block SHALL be in IDLE, with k_sram_read_en, k_sram_address, k_address, k_data, k_valid, address_read_complete and busy all 0.
REQ-027 Reset assertion SHALL take effect immediately regardless of clock; deassertion mid-pass SHALL resume from IDLE, with no data in flight kept.

Configuration
REQ-028 With macro K_FETCH_PIPELINE_EN defined, ISSUE SHALL strobe every cycle and capture SHALL overlap issue, giving one k_valid per cycle after a 2-cycle fill.
REQ-029 With K_FETCH_PIPELINE_EN defined, a full pass SHALL take K_LENGTH+2 cycles from start to address_read_complete.
REQ-030 Without K_FETCH_PIPELINE_EN, the behaviour SHALL be per REQ-018, and a full pass SHALL take 2*K_LENGTH+1 cycles.

Verification
REQ-031 SRAM model holds the SHA-256 K table; start pulse -> k_valid 64 times, k_address 0..63 in order, with k_data[0]=0x428A2F98 and k_data[63]=0xC67178F2.
REQ-032 Pass runs to completion -> address_read_complete high one cycle after the k_address=63 k_valid, and stays high 10 idle cycles later.
REQ-033 start pulses during a pass at capture 20 -> no restart, and the word sequence is unchanged.
REQ-034 clear at capture 30 -> IDLE next edge, no further strobes; a later start -> restart at address 0.
REQ-035 reset_n low mid-pass at capture 15 -> all outputs 0 asynchronously; after release a start gives a complete clean pass.
REQ-036 Both macro settings, start->complete cycle count -> 66 with K_FETCH_PIPELINE_EN, 129 without.
